// File: rtl/cs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cs_pkg
//  Description : Shared definitions for the cosine-similarity feeder and
//                wrapper: FSM state encoding, response status codes, FP32
//                exponent field location and the NaN/Inf test.
//  Revision    : 1.0 - initial release
// ============================================================================
package cs_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_V1 = 3'd1,
        S_LOAD_V2 = 3'd2,
        S_FLUSH   = 3'd3,
        S_START   = 3'd4,
        S_WAIT    = 3'd5,
        S_RESP    = 3'd6
    } cs_state_t;

    localparam logic [1:0] ST_OK        = 2'd0;
    localparam logic [1:0] ST_BAD_INPUT = 2'd1;
    localparam logic [1:0] ST_IP_ERROR  = 2'd2;
    localparam logic [1:0] ST_TIMEOUT   = 2'd3;

    // IEEE-754 single precision exponent field
    localparam int c_fp_exp_msb = 30;
    localparam int c_fp_exp_lsb = 23;

    // An all-ones exponent encodes either infinity or NaN
    function automatic logic is_nan_or_inf(input logic [31:0] word);
        return &word[c_fp_exp_msb:c_fp_exp_lsb];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cs_fp_screen.sv
`default_nettype none
// ============================================================================
//  Module      : cs_fp_screen
//  Description : Combinational FP32 screen. Flags NaN/Inf words and replaces
//                them with zero so downstream accumulation stays finite.
//  Ports       : i_word    - incoming FP32 word
//                o_word    - i_word, or zero when i_word is NaN/Inf
//                o_invalid - high when i_word is NaN/Inf
//  Revision    : 1.0 - initial release
// ============================================================================
module cs_fp_screen
    import cs_pkg::*;
#(
    parameter int D_Len = 32
) (
    input  logic [D_Len-1:0] i_word,
    output logic [D_Len-1:0] o_word,
    output logic             o_invalid
);

    logic w_invalid;

    assign w_invalid = is_nan_or_inf(i_word);
    assign o_invalid = w_invalid;
    assign o_word    = w_invalid ? '0 : i_word;

endmodule
`default_nettype wire

// File: rtl/cs_vector_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cs_vector_loader
//  Description : Upstream feeder for the cosine-similarity wrapper. On go it
//                pulls Ele_Num probe words then Ele_Num reference words from
//                a valid/ready stream, screens each for NaN/Inf, writes them
//                to the wrapper, pulses start, waits for done (with timeout)
//                and returns result + status on a valid/ready response port.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                go, busy              - command / activity indication
//                s_valid/s_ready/s_data- input word stream
//                cs_we/cs_vct_sel/cs_data/cs_start - wrapper write/start
//                cs_done/cs_error/cs_result        - wrapper completion
//                res_valid/res_ready/res_data/res_status - response
//  Revision    : 1.0 - initial release
// ============================================================================
module cs_vector_loader
    import cs_pkg::*;
#(
    parameter int D_Len   = 32,
    parameter int Ele_Num = 128,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    output logic             busy,
    input  logic             s_valid,
    input  logic [D_Len-1:0] s_data,
    output logic             s_ready,
    output logic             cs_we,
    output logic             cs_vct_sel,
    output logic [D_Len-1:0] cs_data,
    output logic             cs_start,
    input  logic             cs_done,
    input  logic             cs_error,
    input  logic [D_Len-1:0] cs_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [D_Len-1:0] res_data,
    output logic [1:0]       res_status
);

    localparam int c_cnt_w = (Ele_Num > 1) ? $clog2(Ele_Num) : 1;
    localparam int c_tmo_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_last_elem = c_cnt_w'(Ele_Num - 1);
    localparam logic [c_tmo_w-1:0] c_last_tmo  = c_tmo_w'(TIMEOUT - 1);

    cs_state_t          r_state;
    logic [c_cnt_w-1:0] r_elem;
    logic [c_tmo_w-1:0] r_tmo;
    logic               r_bad;
    logic               r_busy;
    logic               r_s_ready;
    logic               r_cs_we;
    logic               r_cs_vct_sel;
    logic [D_Len-1:0]   r_cs_data;
    logic               r_cs_start;
    logic               r_res_valid;
    logic [D_Len-1:0]   r_res_data;
    logic [1:0]         r_res_status;

    logic               w_hs;
    logic [D_Len-1:0]   w_scr_word;
    logic               w_scr_invalid;

    cs_fp_screen #(
        .D_Len (D_Len)
    ) u_screen (
        .i_word    (s_data),
        .o_word    (w_scr_word),
        .o_invalid (w_scr_invalid)
    );

    // s_ready is only ever high in the load states, so this is the handshake
    assign w_hs = s_valid & r_s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_elem       <= '0;
            r_tmo        <= '0;
            r_bad        <= 1'b0;
            r_busy       <= 1'b0;
            r_s_ready    <= 1'b0;
            r_cs_we      <= 1'b0;
            r_cs_vct_sel <= 1'b0;
            r_cs_data    <= '0;
            r_cs_start   <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_status <= ST_OK;
        end else begin
            r_cs_we    <= 1'b0;
            r_cs_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_state   <= S_LOAD_V1;
                        r_elem    <= '0;
                        r_bad     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_s_ready <= 1'b1;
                    end
                end
                S_LOAD_V1, S_LOAD_V2: begin
                    if (w_hs) begin
                        // Bad words are still written (as zero) so the
                        // wrapper's write address stays in step
                        r_cs_we      <= 1'b1;
                        r_cs_data    <= w_scr_word;
                        r_cs_vct_sel <= (r_state == S_LOAD_V2);
                        r_bad        <= r_bad | w_scr_invalid;
                        if (r_elem == c_last_elem) begin
                            r_elem <= '0;
                            if (r_state == S_LOAD_V1) begin
                                r_state <= S_LOAD_V2;
                            end else begin
                                r_state   <= S_FLUSH;
                                r_s_ready <= 1'b0;
                            end
                        end else begin
                            r_elem <= r_elem + c_cnt_w'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    // Last write is on the bus this cycle; start follows it
                    if (r_bad) begin
                        r_state      <= S_RESP;
                        r_res_valid  <= 1'b1;
                        r_res_status <= ST_BAD_INPUT;
                        r_res_data   <= '0;
                    end else begin
                        r_state    <= S_START;
                        r_cs_start <= 1'b1;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT;
                    r_tmo   <= '0;
                end
                S_WAIT: begin
                    // Error outranks done when both arrive together
                    if (cs_error) begin
                        r_state      <= S_RESP;
                        r_res_valid  <= 1'b1;
                        r_res_status <= ST_IP_ERROR;
                        r_res_data   <= '0;
                    end else if (cs_done) begin
                        r_state      <= S_RESP;
                        r_res_valid  <= 1'b1;
                        r_res_status <= ST_OK;
                        r_res_data   <= cs_result;
                    end else if (r_tmo == c_last_tmo) begin
                        r_state      <= S_RESP;
                        r_res_valid  <= 1'b1;
                        r_res_status <= ST_TIMEOUT;
                        r_res_data   <= '0;
                    end else begin
                        r_tmo <= r_tmo + c_tmo_w'(1);
                    end
                end
                S_RESP: begin
                    if (res_ready) begin
                        r_state     <= S_IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_s_ready   <= 1'b0;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign s_ready    = r_s_ready;
    assign cs_we      = r_cs_we;
    assign cs_vct_sel = r_cs_vct_sel;
    assign cs_data    = r_cs_data;
    assign cs_start   = r_cs_start;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_status = r_res_status;

endmodule
`default_nettype wire

// File: tb/tb_cs_vector_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cs_vector_loader
//  Description : Self-checking bench for cs_vector_loader with a behavioural
//                wrapper stub (done after T_IP cycles, never, or sticky error).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cs_vector_loader;

    localparam int N    = 128;
    localparam int NW   = 2 * N;
    localparam int TMO  = 16;
    localparam int T_IP = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        cs_done = 1'b0;
    logic        cs_error = 1'b0;
    logic [31:0] cs_result = 32'h3F800000;
    logic        res_ready = 1'b0;
    logic        busy, s_ready, cs_we, cs_vct_sel, cs_start, res_valid;
    logic [31:0] cs_data, res_data;
    logic [1:0]  res_status;

    cs_vector_loader #(
        .D_Len   (32),
        .Ele_Num (N),
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .go         (go),
        .busy       (busy),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .cs_we      (cs_we),
        .cs_vct_sel (cs_vct_sel),
        .cs_data    (cs_data),
        .cs_start   (cs_start),
        .cs_done    (cs_done),
        .cs_error   (cs_error),
        .cs_result  (cs_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_status (res_status)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;
    vec_t tbl [8];

    logic [31:0] words [NW];
    logic [31:0] expw  [NW];
    logic [31:0] we_data [NW];
    logic        we_sel  [NW];
    int we_cnt, start_cnt, start_cyc, last_we_cyc, res_cyc, go_cyc, stub_mode;
    bit res_seen;
    int n_chk = 0;
    int n_err = 0;

    // Write/start/response monitor plus wrapper stub.
    // stub_mode: 0 = done T_IP cycles after start, 1 = never done,
    //            2 = error 3 cycles after start, sticky until reset.
    always @(negedge clk) begin
        if (cs_we) begin
            if (we_cnt < NW) begin
                we_data[we_cnt] = cs_data;
                we_sel[we_cnt]  = cs_vct_sel;
            end
            we_cnt++;
            last_we_cyc = cyc;
        end
        if (cs_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (res_valid && !res_seen) begin
            res_seen = 1'b1;
            res_cyc  = cyc;
        end
        if (!rst_n)
            cs_error = 1'b0;
        else if (stub_mode == 2 && start_cnt > 0 && cyc >= start_cyc + 3)
            cs_error = 1'b1;
        cs_done = (stub_mode == 0 && start_cnt > 0 && cyc >= start_cyc + T_IP);
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fill(input logic [31:0] base, input bit incr);
        for (int i = 0; i < NW; i++) begin
            words[i] = incr ? base + 32'(i) : base;
            expw[i]  = words[i];
        end
    endtask

    // Issue go and feed words[0 .. stop_at-1]; when stop_at == NW also wait
    // for the response to appear.
    task automatic run_txn(input int mode, input bit gaps, input int stop_at);
        int  i;
        int  guard;
        bit  ph;
        we_cnt = 0; start_cnt = 0; res_seen = 1'b0; stub_mode = mode;
        start_cyc = 0; last_we_cyc = 0; res_cyc = 0;
        @(negedge clk);
        go = 1'b1;
        go_cyc = cyc;
        i = 0; guard = 0; ph = 1'b0;
        while (i < stop_at && guard < 4 * NW) begin
            @(negedge clk);
            go = 1'b0;
            guard++;
            ph = gaps ? ~ph : 1'b1;
            s_valid = ph;
            s_data  = words[i];
            if (ph && s_ready) i++;
        end
        chk("words_accepted", 96'(i), 96'(stop_at));
        @(negedge clk);
        s_valid = 1'b0;
        if (stop_at == NW) begin
            guard = 0;
            while (!res_valid && guard < 400) begin
                @(negedge clk);
                guard++;
            end
            #1;
            chk("res_valid_seen", 96'(res_valid), 96'(1));
        end
    endtask

    task automatic check_writes(input int exp_starts);
        int bad_sel = 0;
        int bad_dat = 0;
        chk("we_count", 96'(we_cnt), 96'(NW));
        for (int i = 0; i < NW; i++) begin
            if (we_sel[i] !== (i >= N)) bad_sel++;
            if (we_data[i] !== expw[i]) bad_dat++;
        end
        chk("vct_sel_errors", 96'(bad_sel), 96'(0));
        chk("cs_data_errors", 96'(bad_dat), 96'(0));
        chk("start_count", 96'(start_cnt), 96'(exp_starts));
    endtask

    // Hold res_ready low for 'hold' cycles (optionally waving go), then accept
    task automatic ack(input int hold, input bit wave_go, input logic [1:0] st,
                       input logic [31:0] dat);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            go = wave_go;
            chk("hold_valid", 96'(res_valid), 96'(1));
            chk("hold_status", 96'(res_status), 96'(st));
            chk("hold_data", 96'(res_data), 96'(dat));
        end
        @(negedge clk);
        go = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("valid_after_ack", 96'(res_valid), 96'(0));
        chk("idle_after_ack", 96'(busy), 96'(0));
    endtask

    function automatic logic [95:0] all_outs();
        return 96'({busy, s_ready, cs_we, cs_vct_sel, cs_data, cs_start,
                    res_valid, res_data, res_status});
    endfunction

    initial begin
        tbl[0] = '{din: 32'h3F800000, dout: 32'h3F800000};
        tbl[1] = '{din: 32'h7F800000, dout: 32'h00000000};
        tbl[2] = '{din: 32'hFF800000, dout: 32'h00000000};
        tbl[3] = '{din: 32'h7FC00000, dout: 32'h00000000};
        tbl[4] = '{din: 32'h7F7FFFFF, dout: 32'h7F7FFFFF};
        tbl[5] = '{din: 32'h00000000, dout: 32'h00000000};
        tbl[6] = '{din: 32'h80000001, dout: 32'h80000001};
        tbl[7] = '{din: 32'hFFFFFFFF, dout: 32'h00000000};
        stub_mode = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 96'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", all_outs(), 96'(0));

        // Nominal: 256 x 1.0, done 10 cycles after start
        fill(32'h3F800000, 1'b0);
        run_txn(0, 1'b0, NW);
        check_writes(1);
        chk("start_after_last_we", 96'(start_cyc - last_we_cyc), 96'(1));
        chk("nominal_status", 96'(res_status), 96'(0));
        chk("nominal_data", 96'(res_data), 96'(32'h3F800000));
        chk("nominal_latency", 96'(res_cyc - go_cyc + 1), 96'(2 * N + 4 + T_IP));
        ack(0, 1'b0, 2'd0, 32'h3F800000);

        // Screen table applied as the first words of vector 1
        fill(32'h3F800000, 1'b0);
        foreach (tbl[i]) begin
            words[i] = tbl[i].din;
            expw[i]  = tbl[i].dout;
        end
        run_txn(0, 1'b0, NW);
        check_writes(0);
        chk("table_status", 96'(res_status), 96'(1));
        ack(0, 1'b0, 2'd1, 32'h0);

        // Bad input: word 5 of vector 2 is a NaN
        fill(32'h3F800000, 1'b0);
        words[N + 5] = 32'h7FC00000;
        expw[N + 5]  = 32'h00000000;
        run_txn(0, 1'b0, NW);
        check_writes(0);
        chk("bad_status", 96'(res_status), 96'(1));
        chk("bad_data", 96'(res_data), 96'(0));
        ack(0, 1'b0, 2'd1, 32'h0);

        // Timeout: 16 WAIT cycles, response on the 17th cycle after START
        fill(32'h3F800000, 1'b0);
        run_txn(1, 1'b0, NW);
        chk("timeout_status", 96'(res_status), 96'(3));
        chk("timeout_data", 96'(res_data), 96'(0));
        chk("timeout_delay", 96'(res_cyc - start_cyc), 96'(TMO + 1));
        ack(0, 1'b0, 2'd3, 32'h0);

        // IP error with 5 cycles of backpressure and go waved during RESP
        run_txn(2, 1'b0, NW);
        chk("iperr_status", 96'(res_status), 96'(2));
        chk("iperr_data", 96'(res_data), 96'(0));
        ack(5, 1'b1, 2'd2, 32'h0);
        // Error stays sticky, so the next transaction also reports it
        run_txn(2, 1'b0, NW);
        chk("sticky_status", 96'(res_status), 96'(2));
        ack(0, 1'b0, 2'd2, 32'h0);

        // Stream gaps, reset while loading vector 2
        fill(32'h40000000, 1'b1);
        run_txn(0, 1'b1, N + 12);
        chk("in_load_v2", 96'({busy, s_ready, cs_vct_sel}), 96'(3'b111));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 96'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        res_seen = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("no_resp_after_reset", 96'({res_seen, busy}), 96'(0));

        // Full transaction with gaps after the reset
        run_txn(0, 1'b1, NW);
        check_writes(1);
        chk("gaps_status", 96'(res_status), 96'(0));
        chk("gaps_data", 96'(res_data), 96'(32'h3F800000));
        ack(0, 1'b0, 2'd0, 32'h3F800000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
